div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
Sequencing controller for the programmable clock divider (ratios 2..7, period = N clk cycles, phase 0 = output-high start state).
- Holds a small programmable table of (ratio, repeat-count) entries and drives the divider's 3-bit ratio select.
- Changes the ratio only on period boundaries, so no truncated or stretched periods reach the divided clock.
- Mirrors the divider's phase internally and sits directly beside the divider instance.

Parameters:
DEPTH, 4, number of sequence table entries (power of two)
REP_W, 4, width of per-entry repeat count (1..2^REP_W-1 periods; 0 = end-of-sequence marker)
IDLE_RATIO, 3'd2, ratio driven while idle and after reset

Ports:
clk  input  1  system clock, same clock as the divider
reset  input  1  asynchronous, active-high; also resets the divider
cfg_we  input  1  table write strobe
cfg_addr  input  $clog2(DEPTH)  table entry index
cfg_ratio  input  3  ratio for entry (legal 2..7)
cfg_reps  input  REP_W  periods to hold entry; 0 terminates sequence
start  input  1  pulse: begin sequence at entry 0
stop  input  1  pulse: abort at next boundary
loop  input  1  sampled with start; 1 = wrap to entry 0 at end
div  output  3  ratio select to divider
period_start  output  1  high while mirrored phase == 0
busy  output  1  high in ARM or RUN
entry_idx  output  $clog2(DEPTH)  entry currently applied
seq_done  output  1  one-cycle pulse on normal (non-loop) completion
cfg_err  output  1  one-cycle pulse, cycle after an illegal-ratio write

Behaviour:
- Reset values:
  - div = IDLE_RATIO; phase = 0; state IDLE; entry_idx = 0.
  - busy, seq_done, cfg_err = 0.
  - All table entries = (ratio 2, reps 0).
- Phase mirror:
  - phase counts 0..div-1 every clk.
  - boundary = (phase == div-1).
  - On a boundary edge, phase <= 0 and any div update lands on the same edge. The divider's next period therefore uses the new ratio in full.
  - Between boundaries, div never changes.
- FSM states IDLE, ARM, RUN. All transitions listed below occur only on boundary edges unless noted.
  - IDLE:
    - start (and no stop) -> ARM immediately; capture loop into loop_r.
    - start while ARM/RUN is ignored.
  - ARM, at boundary:
    - If table[0].reps == 0: seq_done pulse, div <= IDLE_RATIO, -> IDLE.
    - Else: div <= table[0].ratio, entry_idx <= 0, rep_cnt <= 0, -> RUN.
  - RUN, at boundary, when rep_cnt < reps-1: rep_cnt++, div unchanged.
  - RUN, at boundary, when rep_cnt == reps-1: advance to next = entry_idx+1.
    - End is reached if next == DEPTH or table[next].reps == 0.
    - Not at end: load table[next].ratio, rep_cnt <= 0.
    - At end with loop_r = 1: reload entry 0; if entry 0 has reps == 0, treat as non-loop end.
    - At end with loop_r = 0: div <= IDLE_RATIO, -> IDLE, seq_done asserted on the cycle after the boundary edge.
- stop:
  - stop in ARM/RUN sets stop_pend.
  - At the next boundary: div <= IDLE_RATIO, -> IDLE, no seq_done, stop_pend cleared.
  - stop in IDLE clears nothing and has no effect.
  - stop and start in the same IDLE cycle: stop wins, start dropped.
- Table writes:
  - Accepted in any state.
  - cfg_ratio < 2 rejects the entire write (table unchanged) and pulses cfg_err.
  - A write to the entry currently applied does not alter the live div or rep target. The entry's ratio and reps are latched at load time.
- Table read is combinational from registers; div is always a register output, so no glitches reach the divider.
- Reset mid-sequence: everything returns to reset values asynchronously, including the table.

Decomposition:
- Package div_seq_pkg holds:
  - state enum {IDLE, ARM, RUN};
  - typedef struct entry_t {logic [2:0] ratio; logic [REP_W-1:0] reps;};
  - constant MIN_RATIO = 3'd2.
- One natural sub-module: div_phase_mirror (phase counter + boundary flag), reusable wherever divider phase must be tracked.
- Table and FSM stay in the top.

Test Plan:
- Reset, then idle 12 clks -> div = 2, period_start every 2nd cycle, busy = 0, seq_done never pulses.
- Table {(3,2),(5,1),(x,0)}, start, loop = 0 -> div stays 2 until the next boundary.
  - Then div = 3 for exactly 6 clks, then div = 5 for exactly 5 clks.
  - Then div = 2, seq_done one-cycle pulse, busy falls.
- Same table with loop = 1 -> pattern 3,3,5 periods repeats for 3 iterations, seq_done never asserted.
  - Then stop mid-period -> div returns to 2 only at the end of the current period, no seq_done.
- Write cfg_ratio = 1 to entry 2 -> cfg_err pulse next cycle, entry 2 unchanged.
  - Write (7,3) to entry 1 while entry 1 is applied -> current entry unaffected, new values seen on the next loop pass.
- All four entries with reps = 1, ratios 2,7,4,6 -> period lengths 2,7,4,6 exactly, then end at entry_idx = 3 → seq_done (DEPTH wrap boundary).
- Assert reset during RUN with div = 7 at phase 4 -> div = 2, phase = 0, busy = 0 immediately.
  - Table reads back empty: a following start gives seq_done with no RUN.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divider sequencing controller.
package div_seq_pkg;

  localparam logic [2:0] MIN_RATIO   = 3'd2;
  localparam int         ENTRY_REP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_e;

  typedef struct packed {
    logic [2:0]             ratio;
    logic [ENTRY_REP_W-1:0] reps;
  } entry_t;

endpackage

// File: rtl/div_phase_mirror.sv
// Tracks the divider's phase so ratio changes can be timed to period edges.
module div_phase_mirror (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] div,
  output logic [2:0] phase,
  output logic       boundary
);

  logic [2:0] phase_q, phase_d;

  assign boundary = (phase_q == div - 3'd1);
  assign phase    = phase_q;

  always_comb begin
    phase_d = phase_q + 3'd1;
    if (boundary) phase_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Steps the clock divider through a programmed ratio table,
// changing the ratio only on whole-period boundaries.
module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter int         REP_W      = 4,
  parameter logic [2:0] IDLE_RATIO = 3'd2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [2:0]               cfg_ratio,
  input  logic [REP_W-1:0]         cfg_reps,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic [2:0]               div,
  output logic                     period_start,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] entry_idx,
  output logic                     seq_done,
  output logic                     cfg_err
);

  localparam int              IW      = $clog2(DEPTH);
  localparam logic [REP_W-1:0] REP_ONE = 1;
  localparam logic [IW:0]     IDX_ONE = 1;

  state_e           state_q, state_d;
  logic [2:0]       div_q, div_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic             loop_q, loop_d;
  logic             stop_pend_q, stop_pend_d;
  logic             seq_done_q, seq_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic [2:0]       tbl_ratio_q [DEPTH];
  logic [2:0]       tbl_ratio_d [DEPTH];
  logic [REP_W-1:0] tbl_reps_q  [DEPTH];
  logic [REP_W-1:0] tbl_reps_d  [DEPTH];

  logic [2:0]       phase;
  logic             boundary;
  logic [IW:0]      next_w;
  logic             at_end;
  logic             abort;
  logic             to_idle;
  logic             load_en;
  logic [IW-1:0]    load_idx;

  div_phase_mirror u_phase (
    .clk      (clk),
    .reset    (reset),
    .div      (div_q),
    .phase    (phase),
    .boundary (boundary)
  );

  always_comb begin
    tbl_ratio_d = tbl_ratio_q;
    tbl_reps_d  = tbl_reps_q;
    cfg_err_d   = cfg_we && (cfg_ratio < MIN_RATIO);
    if (cfg_we && !cfg_err_d) begin
      tbl_ratio_d[cfg_addr] = cfg_ratio;
      tbl_reps_d[cfg_addr]  = cfg_reps;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    idx_d       = idx_q;
    rep_cnt_d   = rep_cnt_q;
    reps_d      = reps_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;
    seq_done_d  = 1'b0;
    to_idle     = 1'b0;
    load_en     = 1'b0;
    load_idx    = '0;
    next_w      = {1'b0, idx_q} + IDX_ONE;
    at_end      = next_w[IW] ||
                  (tbl_reps_q[next_w[IW-1:0]] == '0);
    abort       = stop_pend_q || stop;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = ARM;
          loop_d  = loop;
        end
      end
      ARM, RUN: begin
        stop_pend_d = abort;
        if (boundary) begin
          if (abort) begin
            to_idle = 1'b1;
          end else if (state_q == ARM) begin
            if (tbl_reps_q[0] == '0) begin
              to_idle    = 1'b1;
              seq_done_d = 1'b1;
            end else begin
              load_en = 1'b1;
            end
          end else if (rep_cnt_q != reps_q - REP_ONE) begin
            rep_cnt_d = rep_cnt_q + REP_ONE;
          end else if (!at_end) begin
            load_en  = 1'b1;
            load_idx = next_w[IW-1:0];
          end else if (loop_q && tbl_reps_q[0] != '0) begin
            load_en = 1'b1;
          end else begin
            to_idle    = 1'b1;
            seq_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Ratio and reps are copied out so later table writes cannot disturb the live entry.
    if (load_en) begin
      state_d   = RUN;
      div_d     = tbl_ratio_q[load_idx];
      reps_d    = tbl_reps_q[load_idx];
      idx_d     = load_idx;
      rep_cnt_d = '0;
    end
    if (to_idle) begin
      state_d     = IDLE;
      div_d       = IDLE_RATIO;
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= IDLE_RATIO;
      idx_q       <= '0;
      rep_cnt_q   <= '0;
      reps_q      <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      seq_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_ratio_q[i] <= MIN_RATIO;
        tbl_reps_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      rep_cnt_q   <= rep_cnt_d;
      reps_q      <= reps_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
      seq_done_q  <= seq_done_d;
      cfg_err_q   <= cfg_err_d;
      tbl_ratio_q <= tbl_ratio_d;
      tbl_reps_q  <= tbl_reps_d;
    end
  end

  assign div          = div_q;
  assign period_start = (phase == 3'd0);
  assign busy         = (state_q != IDLE);
  assign entry_idx    = idx_q;
  assign seq_done     = seq_done_q;
  assign cfg_err      = cfg_err_q;

endmodule
